// File: rtl/start_sequencer.sv
// start_sequencer: FIFO-buffered request feeder that strobes an idle timer once per request and reports completion by tag.
module start_sequencer #(
  parameter int ID_W  = 4,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [ID_W-1:0]          i_req_id,
  output logic                     o_start,
  input  logic                     i_busy,
  output logic                     o_done,
  output logic [ID_W-1:0]          o_done_id,
  output logic [$clog2(DEPTH):0]   o_fill
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t r_state, w_next;
  logic [ID_W-1:0] r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic [ID_W-1:0] r_tag, r_done_id;
  logic r_done;
  logic w_full, w_empty, w_push, w_pop, w_done;
  assign w_full      = (r_wr ^ r_rd) == {1'b1, {AW{1'b0}}};
  assign w_empty     = r_wr == r_rd;
  assign w_push      = i_req_valid && !w_full;
  assign o_req_ready = !w_full;
  assign o_fill      = r_wr - r_rd;
  assign o_start     = r_state == ISSUE;
  assign o_done      = r_done;
  assign o_done_id   = r_done_id;
  always_comb begin
    w_pop  = r_state == IDLE && !w_empty && !i_busy;
    w_done = r_state == WAIT && !i_busy;
    w_next = w_pop ? ISSUE : r_state == ISSUE ? WAIT : w_done ? IDLE : r_state;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_wr      <= '0;
      r_rd      <= '0;
      r_tag     <= '0;
      r_done    <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd  <= r_rd + 1'b1;
        r_tag <= r_mem[r_rd[AW-1:0]];
      end
      if (w_done) r_done_id <= r_tag;
    end
  end
  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_req_id;
  end
endmodule

// File: tb/tb_start_sequencer.sv
// tb_start_sequencer: directed bench with a busy-countdown timer model driving i_busy.
module tb_start_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, start, done, ext_busy = 1'b0, busy;
  logic [3:0] req_id = '0, done_id;
  logic [2:0] fill;
  int checks = 0, failures = 0, cyc = 0, tcnt = 0, n_len = 22;
  int st_q[$], dn_q[$], id_q[$];
  int acc, rel, bad;
  bit first, all_first;
  start_sequencer #(.ID_W(4), .DEPTH(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_id(req_id), .o_start(start), .i_busy(busy), .o_done(done),
    .o_done_id(done_id), .o_fill(fill)
  );
  always #5 clk = ~clk;
  assign busy = (tcnt != 0) || ext_busy;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (start) tcnt <= n_len - 1;
    else if (tcnt != 0) tcnt <= tcnt - 1;
  end
  always @(negedge clk) begin
    if (start) st_q.push_back(cyc);
    if (done) begin
      dn_q.push_back(cyc);
      id_q.push_back(int'(done_id));
    end
  end
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clearq();
    st_q.delete();
    dn_q.delete();
    id_q.delete();
  endtask
  function automatic int qv(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999;
  endfunction
  task automatic push(input logic [3:0] id, output int acc_t, output bit ok_first);
    int g = 0;
    req_id = id;
    req_valid = 1'b1;
    ok_first = req_ready;
    while (!req_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check("push_timeout", 0, 1);
    @(negedge clk);
    acc_t = cyc;
    req_valid = 1'b0;
  endtask
  initial begin
    run(2);
    check("rst_fill", int'(fill), 0);
    check("rst_ready", int'(req_ready), 1);
    check("rst_start", int'(start), 0);
    check("rst_done", int'(done), 0);
    check("rst_done_id", int'(done_id), 0);
    rst = 1'b0;
    run(2);
    check("idle_no_start", st_q.size(), 0);
    // single request, N = 22
    clearq();
    push(4'h5, acc, first);
    check("t1_fill_after_accept", int'(fill), 1);
    run(40);
    check("t1_start_cnt", st_q.size(), 1);
    check("t1_start_lat", qv(st_q, 0) - acc, 1);
    check("t1_done_cnt", dn_q.size(), 1);
    check("t1_done_lat", qv(dn_q, 0) - qv(st_q, 0), 23);
    check("t1_done_id", qv(id_q, 0), 5);
    check("t1_fill_end", int'(fill), 0);
    // four back-to-back pushes
    clearq();
    all_first = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push(4'(i), acc, first);
      all_first &= first;
    end
    run(110);
    check("t2_ready_held", int'(all_first), 1);
    check("t2_start_cnt", st_q.size(), 4);
    check("t2_done_cnt", dn_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) check("t2_period", qv(st_q, i) - qv(st_q, i - 1), 24);
      check("t2_done_id", qv(id_q, i), i + 1);
    end
    // fill to DEPTH with one in flight
    clearq();
    for (int i = 7; i <= 11; i++) push(4'(i), acc, first);
    check("t3_fill_full", int'(fill), 4);
    check("t3_ready_full", int'(req_ready), 0);
    req_id = 4'hC;
    req_valid = 1'b1;
    bad = 0;
    for (int g = 0; g < 60 && !req_ready; g++) begin
      if (fill != 3'd4) bad++;
      @(negedge clk);
    end
    check("t3_held_full", bad, 0);
    check("t3_ready_back", int'(req_ready), 1);
    check("t3_fill_after_pop", int'(fill), 3);
    check("t3_pop_edge_start", int'(start), 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("t3_fifth_taken", int'(fill), 4);
    run(140);
    check("t3_done_cnt", dn_q.size(), 6);
    check("t3_done_id1", qv(id_q, 1), 8);
    check("t3_done_id5", qv(id_q, 5), 12);
    // timer length 1: busy never rises
    clearq();
    n_len = 1;
    push(4'hA, acc, first);
    push(4'hB, acc, first);
    run(12);
    check("t4_start_cnt", st_q.size(), 2);
    check("t4_period", qv(st_q, 1) - qv(st_q, 0), 3);
    check("t4_done_lat0", qv(dn_q, 0) - qv(st_q, 0), 2);
    check("t4_done_lat1", qv(dn_q, 1) - qv(st_q, 1), 2);
    check("t4_id0", qv(id_q, 0), 10);
    check("t4_id1", qv(id_q, 1), 11);
    // external busy holds issue
    clearq();
    n_len = 22;
    ext_busy = 1'b1;
    push(4'h3, acc, first);
    push(4'h4, acc, first);
    run(10);
    check("t5_no_start", st_q.size(), 0);
    check("t5_fill", int'(fill), 2);
    ext_busy = 1'b0;
    rel = cyc;
    run(3);
    check("t5_release_lat", qv(st_q, 0) - rel, 1);
    push(4'h5, acc, first);
    check("t6_fill_wait", int'(fill), 2);
    // asynchronous reset mid-WAIT
    rst = 1'b1;
    ext_busy = 1'b1;
    #1;
    check("t6_rst_fill", int'(fill), 0);
    check("t6_rst_ready", int'(req_ready), 1);
    check("t6_rst_start", int'(start), 0);
    check("t6_rst_done", int'(done), 0);
    check("t6_rst_done_id", int'(done_id), 0);
    @(negedge clk);
    rst = 1'b0;
    clearq();
    run(40);
    check("t6_no_start_busy", st_q.size(), 0);
    check("t6_no_done", dn_q.size(), 0);
    ext_busy = 1'b0;
    run(30);
    check("t6_no_start_empty", st_q.size(), 0);
    check("t6_fill_end", int'(fill), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
